// File: rtl/uart_hex_monitor_pkg.sv
// Shared types, constants and the 7-segment font for the UART hex monitor.
package uart_hex_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

  localparam int         OVS_HALF  = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7f;

  // Active-low segments, bit0 = a .. bit6 = g.
  function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'ha:    seg = 7'h08;
      4'hb:    seg = 7'h03;
      4'hc:    seg = 7'h46;
      4'hd:    seg = 7'h21;
      4'he:    seg = 7'h06;
      default: seg = 7'h0e;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/uart_hex_monitor_digit_pair.sv
// Registered two-digit hex display driver for one received byte slot.
module hex_digit_pair
  import uart_hex_monitor_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic [6:0] seg_hi_o,
  output logic [6:0] seg_lo_o
);

  logic [6:0] seg_hi_d, seg_hi_q;
  logic [6:0] seg_lo_d, seg_lo_q;

  always_comb begin
    seg_hi_d = valid_i ? seg7_hex(data_i[7:4]) : SEG_BLANK;
    seg_lo_d = valid_i ? seg7_hex(data_i[3:0]) : SEG_BLANK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_hi_q <= SEG_BLANK;
      seg_lo_q <= SEG_BLANK;
    end else begin
      seg_hi_q <= seg_hi_d;
      seg_lo_q <= seg_lo_d;
    end
  end

  assign seg_hi_o = seg_hi_q;
  assign seg_lo_o = seg_lo_q;

endmodule

// File: rtl/uart_hex_monitor.sv
// 8N1 UART receiver showing the last four bytes on HEX7..HEX0.
// Define UART_HEX_MONITOR_PARITY_EN to receive 8E1 frames instead.
module uart_hex_monitor
  import uart_hex_monitor_pkg::*;
#(
  parameter int CLK_MHZ  = 50,
  parameter int BAUD     = 115200,
  parameter int OVS      = 16,
  parameter int TICK_DIV = (CLK_MHZ * 1000000 + BAUD * OVS / 2) / (BAUD * OVS)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       rx_active,
  output logic [7:0] byte_cnt,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [6:0] hex6,
  output logic [6:0] hex7
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          sync1_q, sync2_q, prev_q;
  logic [TW-1:0] tick_cnt_d, tick_cnt_q;
  logic [3:0]    os_cnt_d, os_cnt_q;
  logic [2:0]    bit_idx_d, bit_idx_q;
  logic [7:0]    shift_d, shift_q;
  state_e        state_d, state_q;
  logic          rx_valid_d, rx_valid_q;
  logic [7:0]    rx_data_d, rx_data_q;
  logic          frame_err_d, frame_err_q;
  logic [7:0]    byte_cnt_d, byte_cnt_q;
  logic [3:0][7:0] slot_d, slot_q;
  logic [3:0]    slot_vld_d, slot_vld_q;
  logic          tick, os_full, os_half, frame_ok;
`ifdef UART_HEX_MONITOR_PARITY_EN
  logic          parity_bad_d, parity_bad_q;
`endif

  assign tick    = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign os_full = tick && (os_cnt_q == 4'(OVS - 1));
  assign os_half = tick && (os_cnt_q == 4'(OVS_HALF - 1));

  // A good frame needs a high stop bit and, when enabled, a matching parity bit.
`ifdef UART_HEX_MONITOR_PARITY_EN
  assign frame_ok = sync2_q && !parity_bad_q;
`else
  assign frame_ok = sync2_q;
`endif

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    os_cnt_d    = os_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    frame_err_d = frame_err_q;
    byte_cnt_d  = byte_cnt_q;
    slot_d      = slot_q;
    slot_vld_d  = slot_vld_q;
`ifdef UART_HEX_MONITOR_PARITY_EN
    parity_bad_d = parity_bad_q;
`endif
    if (tick) os_cnt_d = os_cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          os_cnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        if (os_half) begin
          os_cnt_d  = '0;
          bit_idx_d = '0;
          state_d   = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (os_full) begin
          os_cnt_d  = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_HEX_MONITOR_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_HEX_MONITOR_PARITY_EN
      PARITY: begin
        if (os_full) begin
          os_cnt_d     = '0;
          parity_bad_d = (sync2_q != ^shift_q);
          if (sync2_q != ^shift_q) frame_err_d = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (os_full) begin
          os_cnt_d = '0;
          if (!sync2_q) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end else begin
            state_d = IDLE;
            if (frame_ok) begin
              rx_valid_d = 1'b1;
              rx_data_d  = shift_q;
              byte_cnt_d = byte_cnt_q + 8'd1;
              slot_d     = {slot_q[2:0], shift_q};
              slot_vld_d = {slot_vld_q[2:0], 1'b1};
            end
          end
        end
      end
      BREAK: begin
        // Hold here through a long low line so a break never decodes as data.
        if (sync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      state_q     <= IDLE;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      frame_err_q <= 1'b0;
      byte_cnt_q  <= '0;
      slot_q      <= '0;
      slot_vld_q  <= '0;
    end else begin
      sync1_q     <= uart_rx;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      state_q     <= state_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      frame_err_q <= frame_err_d;
      byte_cnt_q  <= byte_cnt_d;
      slot_q      <= slot_d;
      slot_vld_q  <= slot_vld_d;
    end
  end

`ifdef UART_HEX_MONITOR_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity_bad_q <= 1'b0;
    else          parity_bad_q <= parity_bad_d;
  end
`endif

  logic [3:0][6:0] seg_hi, seg_lo;

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    hex_digit_pair u_pair (
      .clk      (clk),
      .reset_n  (reset_n),
      .data_i   (slot_q[gi]),
      .valid_i  (slot_vld_q[gi]),
      .seg_hi_o (seg_hi[gi]),
      .seg_lo_o (seg_lo[gi])
    );
  end

  assign hex0 = seg_lo[0];
  assign hex1 = seg_hi[0];
  assign hex2 = seg_lo[1];
  assign hex3 = seg_hi[1];
  assign hex4 = seg_lo[2];
  assign hex5 = seg_hi[2];
  assign hex6 = seg_lo[3];
  assign hex7 = seg_hi[3];

  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;
  assign rx_active = (state_q != IDLE);
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_uart_hex_monitor.sv
// Self-checking bench: table-driven frames, corner-case sequences and random frames vs a byte-level model.
module tb_uart_hex_monitor;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_valid, frame_err, rx_active;
  logic [7:0] rx_data, byte_cnt;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  uart_hex_monitor #(.CLK_MHZ(1), .BAUD(15625)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
    .rx_valid(rx_valid), .rx_data(rx_data), .frame_err(frame_err),
    .rx_active(rx_active), .byte_cnt(byte_cnt),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
  );

  always #5 clk = ~clk;

  // Cycle counter and rx_valid monitor
  int         cyc = 0, vcnt = 0, vcyc = 0, dbl = 0;
  logic [7:0] vdata = 8'h00;
  logic       prev_v = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    prev_v <= rx_valid;
    if (rx_valid) begin
      vcnt  <= vcnt + 1;
      vdata <= rx_data;
      vcyc  <= cyc;
      if (prev_v) dbl <= dbl + 1;
    end
  end

  int n_checks = 0, n_err = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte-level reference model: last four good bytes, count, last byte, sticky error
  logic [6:0] font[16];
  logic [7:0] m_slot[4];
  logic       m_vld[4];
  logic [7:0] m_cnt, m_data;
  logic       m_ferr;
  int         start_cyc;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin m_slot[k] = 8'h00; m_vld[k] = 1'b0; end
    m_cnt = 8'h00; m_data = 8'h00; m_ferr = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    for (int k = 3; k > 0; k--) begin m_slot[k] = m_slot[k-1]; m_vld[k] = m_vld[k-1]; end
    m_slot[0] = b; m_vld[0] = 1'b1;
    m_cnt = m_cnt + 8'd1;
    m_data = b;
  endtask

  function automatic logic [55:0] m_hex();
    logic [55:0] r;
    for (int k = 0; k < 4; k++) begin
      r[14*k +: 7]     = m_vld[k] ? font[m_slot[k][3:0]] : 7'h7f;
      r[14*k + 7 +: 7] = m_vld[k] ? font[m_slot[k][7:4]] : 7'h7f;
    end
    return r;
  endfunction

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    uart_rx = 1'b0; start_cyc = cyc; idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; idle(BIT_CLKS); end
`ifdef UART_HEX_MONITOR_PARITY_EN
    uart_rx = par_bit; idle(BIT_CLKS);
`else
    if (par_bit === 1'bx) $display("note: parity bit unknown");
`endif
    uart_rx = stop_bit; idle(BIT_CLKS);
  endtask

  task automatic frame_and_check(input logic [7:0] b, input logic stop_bit, input logic par_ok, input string tag);
    int   base;
    logic good;
    base = vcnt;
    good = stop_bit && par_ok;
    send_frame(b, stop_bit, (^b) ^ !par_ok);
    if (good) model_accept(b);
    else      m_ferr = 1'b1;
    check({tag, "_valid_cnt"}, vcnt - base, good ? 1 : 0);
    check({tag, "_rx_data"}, rx_data, m_data);
    check({tag, "_byte_cnt"}, byte_cnt, m_cnt);
    check({tag, "_frame_err"}, frame_err, m_ferr);
    check({tag, "_rx_active"}, rx_active, !stop_bit);
    check({tag, "_hex"}, {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0}, m_hex());
    $display("frame %s data=%02h stop=%0b par_ok=%0b -> rx_data=%02h byte_cnt=%0d frame_err=%0b",
             tag, b, stop_bit, par_ok, rx_data, byte_cnt, frame_err);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; uart_rx = 1'b1;
    idle(3);
    model_reset();
    reset_n = 1'b1;
    idle(5);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [6:0] hi;
    logic [6:0] lo;
  } vec_t;
  vec_t tbl[8];

  int base;
  logic [7:0] rb;
  logic rstop, rpar;

  initial begin
    font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
    tbl[0] = '{8'h5A, 7'h12, 7'h08};
    tbl[1] = '{8'h01, 7'h40, 7'h79};
    tbl[2] = '{8'h23, 7'h24, 7'h30};
    tbl[3] = '{8'h45, 7'h19, 7'h12};
    tbl[4] = '{8'h67, 7'h02, 7'h78};
    tbl[5] = '{8'h89, 7'h00, 7'h10};
    tbl[6] = '{8'hBC, 7'h03, 7'h46};
    tbl[7] = '{8'hDE, 7'h21, 7'h06};
    model_reset();

    // Reset values
    idle(3);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_active", rx_active, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    check("rst_hex", {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0}, {8{7'h7f}});
    reset_n = 1'b1;
    idle(7);

    // Table: first frame alone, then back-to-back run from a fresh reset
    for (int i = 0; i < 8; i++) begin
      frame_and_check(tbl[i].data, 1'b1, 1'b1, "tbl");
      check("tbl_hex1", hex1, tbl[i].hi);
      check("tbl_hex0", hex0, tbl[i].lo);
      if (i == 0) begin
        check("first_valid_latency_ok", (vcyc - start_cyc >= 604) && (vcyc - start_cyc <= 616), 1);
        check("first_hex7_2_blank", {hex7, hex6, hex5, hex4, hex3, hex2}, {6{7'h7f}});
        do_reset();
      end
      if (i == 5) begin
        check("b2b_byte_cnt", byte_cnt, 5);
        check("b2b_slot3", {hex7, hex6}, {7'h24, 7'h30});
        check("b2b_slot0", {hex1, hex0}, {7'h00, 7'h10});
      end
    end

    // Bad stop bit, held-low line, then recovery
    frame_and_check(8'hA5, 1'b0, 1'b1, "badstop");
    base = vcnt;
    idle(200);
    check("break_active", rx_active, 1);
    check("break_no_valid", vcnt - base, 0);
    uart_rx = 1'b1;
    idle(20);
    check("break_exit_idle", rx_active, 0);
    frame_and_check(8'h3C, 1'b1, 1'b1, "after_break");

    // Reset in the middle of data bit 4
    base = vcnt;
    uart_rx = 1'b0;
    idle(BIT_CLKS * 5 + BIT_CLKS / 2);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    idle(2);
    model_reset();
    check("midrst_rx_active", rx_active, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_byte_cnt", byte_cnt, 0);
    check("midrst_hex", {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0}, {8{7'h7f}});
    reset_n = 1'b1;
    idle(200);
    check("midrst_no_valid", vcnt - base, 0);
    frame_and_check(8'hFF, 1'b1, 1'b1, "after_rst");
    check("ff_hex10", {hex1, hex0}, {7'h0e, 7'h0e});

    // 20-clock glitch
    base = vcnt;
    uart_rx = 1'b0;
    idle(10);
    check("glitch_seen_active", rx_active, 1);
    idle(10);
    uart_rx = 1'b1;
    idle(100);
    check("glitch_idle", rx_active, 0);
    check("glitch_no_valid", vcnt - base, 0);
    check("glitch_frame_err", frame_err, 0);

    // Random frames against the model
    for (int n = 0; n < 24; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
`ifdef UART_HEX_MONITOR_PARITY_EN
      rpar  = ($urandom_range(0, 5) != 0);
`else
      rpar  = 1'b1;
`endif
      frame_and_check(rb, rstop, rpar, "rand");
      if (!rstop) begin
        uart_rx = 1'b1;
        idle(8 + $urandom_range(0, 40));
      end else begin
        idle($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 40));
      end
    end

`ifdef UART_HEX_MONITOR_PARITY_EN
    do_reset();
    frame_and_check(8'h07, 1'b1, 1'b0, "par_bad");
    check("par_bad_err", frame_err, 1);
    frame_and_check(8'h07, 1'b1, 1'b1, "par_good");
    check("par_good_data", vdata, 8'h07);
`endif

    check("valid_single_cycle", dbl, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
